// File: rtl/dma_tile_scheduler.sv
// Double-buffered DMA tile scheduler: an optional weight load, then ping/pong tile
// loads into two SRAM buffers that the compute engine releases once consumed.
module dma_tile_scheduler #(
  parameter int TILE_WORDS = 2704,
  parameter int ADDR_W     = 22,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              go,
  input  logic [CNT_W-1:0]  num_tiles,
  input  logic [ADDR_W-1:0] img_base,
  input  logic [ADDR_W-1:0] weight_base,
  input  logic [31:0]       weight_words,
  output logic [1:0]        dma_start,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [31:0]       dma_size,
  output logic [31:0]       dma_sram_size,
  input  logic              dma_started,
  input  logic              dma_done,
  output logic [1:0]        buf_full,
  input  logic [1:0]        cons_release,
  output logic [CNT_W-1:0]  tiles_loaded,
  output logic              busy,
  output logic              job_done
);

  typedef enum logic [2:0] {
    IDLE, ISSUE_W, WAIT_W, PICK, ISSUE_T, WAIT_T, DRAIN, FINISH
  } state_t;

  localparam logic [ADDR_W-1:0] TILE_STEP = ADDR_W'(TILE_WORDS);
  localparam logic [31:0]       TILE_SIZE = 32'(TILE_WORDS);

  state_t            state_q, state_d;
  logic [1:0]        dma_start_q, dma_start_d;
  logic [ADDR_W-1:0] dma_addr_q, dma_addr_d;
  logic [31:0]       dma_size_q, dma_size_d;
  logic [31:0]       dma_sram_size_q, dma_sram_size_d;
  logic [1:0]        buf_full_q, buf_full_d;
  logic [CNT_W-1:0]  tiles_q, tiles_d;
  logic [CNT_W-1:0]  num_tiles_q, num_tiles_d;
  logic [ADDR_W-1:0] tile_addr_q, tile_addr_d;
  logic              nxt_q, nxt_d;
  logic              busy_q, busy_d;
  logic              job_done_q, job_done_d;
  logic              accept;
  logic              tile_done;

  assign accept    = (state_q == IDLE) && go;
  assign tile_done = (state_q == WAIT_T) && dma_done;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = (weight_words != 32'd0) ? ISSUE_W : PICK;
      ISSUE_W: if (dma_started) state_d = WAIT_W;
      WAIT_W:  if (dma_done) state_d = PICK;
      PICK: begin
        if (tiles_q == num_tiles_q) begin
          state_d = DRAIN;
        end else if (!buf_full_q[nxt_q]) begin
          state_d = ISSUE_T;
        end
      end
      ISSUE_T: if (dma_started) state_d = WAIT_T;
      WAIT_T:  if (dma_done) state_d = PICK;
      DRAIN:   if (buf_full_q == 2'b00) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command outputs are registered from the next state so they appear with it.
  always_comb begin
    dma_start_d     = 2'b00;
    dma_addr_d      = dma_addr_q;
    dma_size_d      = dma_size_q;
    dma_sram_size_d = dma_sram_size_q;
    busy_d          = (state_d != IDLE);
    job_done_d      = (state_d == FINISH);
    case (state_d)
      ISSUE_W: begin
        dma_start_d = 2'b11;
        if (accept) begin
          dma_addr_d      = weight_base;
          dma_size_d      = weight_words;
          dma_sram_size_d = weight_words;
        end
      end
      ISSUE_T: begin
        dma_start_d     = {nxt_q, ~nxt_q};
        dma_addr_d      = tile_addr_q;
        dma_size_d      = TILE_SIZE;
        dma_sram_size_d = TILE_SIZE;
      end
      default: ;
    endcase
  end

  // Tile address advances by one tile per completed load, wrapping at ADDR_W bits.
  always_comb begin
    num_tiles_d = num_tiles_q;
    tile_addr_d = tile_addr_q;
    tiles_d     = tiles_q;
    nxt_d       = nxt_q;
    buf_full_d  = buf_full_q & ~cons_release;
    if (accept) begin
      num_tiles_d = num_tiles;
      tile_addr_d = img_base;
      tiles_d     = '0;
      nxt_d       = 1'b0;
    end
    if (tile_done) begin
      buf_full_d[nxt_q] = 1'b1;
      nxt_d             = ~nxt_q;
      tiles_d           = tiles_q + CNT_W'(1);
      tile_addr_d       = tile_addr_q + TILE_STEP;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dma_start_q     <= 2'b00;
      dma_addr_q      <= '0;
      dma_size_q      <= '0;
      dma_sram_size_q <= '0;
      buf_full_q      <= 2'b00;
      tiles_q         <= '0;
      num_tiles_q     <= '0;
      tile_addr_q     <= '0;
      nxt_q           <= 1'b0;
      busy_q          <= 1'b0;
      job_done_q      <= 1'b0;
    end else begin
      dma_start_q     <= dma_start_d;
      dma_addr_q      <= dma_addr_d;
      dma_size_q      <= dma_size_d;
      dma_sram_size_q <= dma_sram_size_d;
      buf_full_q      <= buf_full_d;
      tiles_q         <= tiles_d;
      num_tiles_q     <= num_tiles_d;
      tile_addr_q     <= tile_addr_d;
      nxt_q           <= nxt_d;
      busy_q          <= busy_d;
      job_done_q      <= job_done_d;
    end
  end

  assign dma_start     = dma_start_q;
  assign dma_addr      = dma_addr_q;
  assign dma_size      = dma_size_q;
  assign dma_sram_size = dma_sram_size_q;
  assign buf_full      = buf_full_q;
  assign tiles_loaded  = tiles_q;
  assign busy          = busy_q;
  assign job_done      = job_done_q;

endmodule

// File: tb/tb_dma_tile_scheduler.sv
// Bench for dma_tile_scheduler: transaction-level model driven by a DMA/consumer
// responder, checked every cycle, plus directed scenarios with literal expectations.
module tb_dma_tile_scheduler;
  localparam int TW = 2704;
  localparam int AW = 22;
  localparam int CW = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          go;
  logic [CW-1:0] num_tiles;
  logic [AW-1:0] img_base, weight_base;
  logic [31:0]   weight_words;
  logic [1:0]    dma_start;
  logic [AW-1:0] dma_addr;
  logic [31:0]   dma_size, dma_sram_size;
  logic          dma_started, dma_done;
  logic [1:0]    buf_full, cons_release;
  logic [CW-1:0] tiles_loaded;
  logic          busy, job_done;

  dma_tile_scheduler #(.TILE_WORDS(TW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .go(go), .num_tiles(num_tiles), .img_base(img_base),
    .weight_base(weight_base), .weight_words(weight_words), .dma_start(dma_start),
    .dma_addr(dma_addr), .dma_size(dma_size), .dma_sram_size(dma_sram_size),
    .dma_started(dma_started), .dma_done(dma_done), .buf_full(buf_full),
    .cons_release(cons_release), .tiles_loaded(tiles_loaded), .busy(busy),
    .job_done(job_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]    code;
    logic [AW-1:0] addr;
    logic [31:0]   size;
    logic [31:0]   sram;
  } cmd_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the job is a precomputed list of commands; buffers and counters follow events.
  cmd_t       m_q[$];
  cmd_t       m_cur;
  bit         m_busy, m_done, m_issuing, m_flight, m_pick, m_drain;
  logic [1:0] m_buf = 2'b00;
  int         m_loaded = 0;

  function automatic void model_step();
    logic [1:0] nb;
    cmd_t c;
    longint a;
    if (RST) begin
      m_q.delete();
      {m_busy, m_done, m_issuing, m_flight, m_pick, m_drain} = '0;
      m_buf = 2'b00;
      m_loaded = 0;
      return;
    end
    nb = m_buf & ~cons_release;
    if (!m_busy) begin
      if (go) begin
        m_busy = 1'b1;
        m_loaded = 0;
        if (weight_words != 32'd0) begin
          c.code = 2'b11; c.addr = weight_base; c.size = weight_words; c.sram = weight_words;
          m_q.push_back(c);
        end
        for (int k = 0; k < int'(num_tiles); k++) begin
          a = (longint'(img_base) + longint'(k) * longint'(TW)) % (longint'(1) << AW);
          c.code = (k % 2 == 0) ? 2'b01 : 2'b10;
          c.addr = AW'(a); c.size = 32'(TW); c.sram = 32'(TW);
          m_q.push_back(c);
        end
        if (weight_words != 32'd0) begin
          m_cur = m_q.pop_front();
          m_issuing = 1'b1;
        end else begin
          m_pick = 1'b1;
        end
      end
    end else if (m_issuing) begin
      if (dma_started) begin
        m_issuing = 1'b0;
        m_flight = 1'b1;
      end
    end else if (m_flight) begin
      if (dma_done) begin
        m_flight = 1'b0;
        m_pick = 1'b1;
        if (m_cur.code != 2'b11) begin
          nb[m_cur.code[1]] = 1'b1;
          m_loaded++;
        end
      end
    end else if (m_pick) begin
      if (m_q.size() == 0) begin
        m_pick = 1'b0;
        m_drain = 1'b1;
      end else if (!m_buf[m_q[0].code[1]]) begin
        m_pick = 1'b0;
        m_cur = m_q.pop_front();
        m_issuing = 1'b1;
      end
    end else if (m_drain) begin
      if (m_buf == 2'b00) begin
        m_drain = 1'b0;
        m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end
    m_buf = nb;
  endfunction

  always @(posedge CLK) model_step();

  task automatic compare_all();
    chk("cyc_job_done", 64'(job_done), 64'(m_done));
    chk("cyc_busy", 64'(busy), 64'(m_busy));
    chk("cyc_buf_full", 64'(buf_full), 64'(m_buf));
    chk("cyc_tiles_loaded", 64'(tiles_loaded), 64'(m_loaded));
    chk("cyc_dma_start", 64'(dma_start), 64'(m_issuing ? m_cur.code : 2'b00));
    if (m_issuing) begin
      chk("cyc_dma_addr", 64'(dma_addr), 64'(m_cur.addr));
      chk("cyc_dma_size", 64'(dma_size), 64'(m_cur.size));
      chk("cyc_dma_sram_size", 64'(dma_sram_size), 64'(m_cur.sram));
    end
  endtask

  // Responder knobs: 0 delay means random; rel_mode 0 none, 1 immediate, 2 random.
  int ack_dly = 0, done_dly = 0, rel_mode = 1;
  bit stray = 1'b0, rnd_go = 1'b0;
  int ack_cnt = 0, cur_ack = 1, done_cnt = 0, cur_done = 1;

  task automatic drive();
    go = 1'b0; dma_started = 1'b0; dma_done = 1'b0; cons_release = 2'b00;
    if (dma_start != 2'b00) begin
      if (ack_cnt == 0) cur_ack = (ack_dly > 0) ? ack_dly : int'($urandom_range(1, 4));
      ack_cnt++;
      if (ack_cnt >= cur_ack) dma_started = 1'b1;
    end else begin
      ack_cnt = 0;
      if (stray && $urandom_range(0, 15) == 0) dma_started = 1'b1;
    end
    if (m_flight) begin
      if (done_cnt == 0) cur_done = (done_dly > 0) ? done_dly : int'($urandom_range(1, 6));
      done_cnt++;
      if (done_cnt >= cur_done) dma_done = 1'b1;
    end else begin
      done_cnt = 0;
      if (stray && $urandom_range(0, 15) == 0) dma_done = 1'b1;
    end
    case (rel_mode)
      1: cons_release = buf_full;
      2: if ($urandom_range(0, 3) == 0) cons_release = 2'($urandom_range(0, 3));
      default: ;
    endcase
  endtask

  cmd_t       obs_q[$];
  int         hold_q[$];
  int         cur_hold = 0;
  int         jd_cnt = 0;
  logic [1:0] prev_start = 2'b00;

  task automatic tick();
    cmd_t rec;
    @(negedge CLK);
    compare_all();
    if (dma_start != 2'b00) begin
      if (prev_start == 2'b00) begin
        rec.code = dma_start; rec.addr = dma_addr; rec.size = dma_size; rec.sram = dma_sram_size;
        obs_q.push_back(rec);
        cur_hold = 0;
      end
      cur_hold++;
    end else if (prev_start != 2'b00) begin
      hold_q.push_back(cur_hold);
    end
    prev_start = dma_start;
    if (job_done) jd_cnt++;
    drive();
  endtask

  task automatic start_job(input int nt, input logic [AW-1:0] ib, input logic [AW-1:0] wb,
                           input logic [31:0] ww);
    obs_q.delete(); hold_q.delete(); jd_cnt = 0;
    go = 1'b1; num_tiles = CW'(nt); img_base = ib; weight_base = wb; weight_words = ww;
    tick();
    num_tiles = CW'($urandom); img_base = AW'($urandom);
    weight_base = AW'($urandom); weight_words = $urandom;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 1;
    while (jd_cnt == 0 && cyc < budget) begin
      if (rnd_go && $urandom_range(0, 15) == 0) go = 1'b1;
      tick();
      cyc++;
    end
    if (jd_cnt == 0) chk("job_done_timeout", 64'(jd_cnt), 64'd1);
    repeat (3) tick();
    chk("job_done_single_pulse", 64'(jd_cnt), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, c;
    RST = 1'b1; go = 1'b0; num_tiles = '0; img_base = '0; weight_base = '0;
    weight_words = '0; dma_started = 1'b0; dma_done = 1'b0; cons_release = 2'b00;
    repeat (3) tick();
    RST = 1'b0;
    chk("rst_dma_start", 64'(dma_start), 64'd0);
    chk("rst_dma_addr", 64'(dma_addr), 64'd0);
    chk("rst_dma_size", 64'(dma_size), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    tick();

    // Weights then two tiles, immediate release.
    rel_mode = 1;
    start_job(2, 22'h100, 22'h2000, 32'd8);
    wait_done(300, cyc);
    chk("ex1_cmd_count", 64'(obs_q.size()), 64'd3);
    if (obs_q.size() == 3) begin
      chk("ex1_w_code", 64'(obs_q[0].code), 64'h3);
      chk("ex1_w_addr", 64'(obs_q[0].addr), 64'h2000);
      chk("ex1_w_size", 64'(obs_q[0].size), 64'd8);
      chk("ex1_w_sram", 64'(obs_q[0].sram), 64'd8);
      chk("ex1_t0_code", 64'(obs_q[1].code), 64'h1);
      chk("ex1_t0_addr", 64'(obs_q[1].addr), 64'h100);
      chk("ex1_t0_size", 64'(obs_q[1].size), 64'd2704);
      chk("ex1_t1_code", 64'(obs_q[2].code), 64'h2);
      chk("ex1_t1_addr", 64'(obs_q[2].addr), 64'hB90);
    end
    chk("ex1_tiles_loaded", 64'(tiles_loaded), 64'd2);
    chk("ex1_busy_after", 64'(busy), 64'd0);

    // Acknowledge delayed by 5 cycles.
    ack_dly = 5;
    start_job(1, 22'h0, 22'h40, 32'd4);
    wait_done(300, cyc);
    ack_dly = 0;
    chk("hold_count", 64'(hold_q.size()), 64'd2);
    if (hold_q.size() >= 1) chk("hold_weights", 64'(hold_q[0]), 64'd5);
    if (hold_q.size() >= 2) chk("hold_tile", 64'(hold_q[1]), 64'd5);

    // Three tiles, no release: third tile must stall until buffer 0 is freed.
    rel_mode = 0;
    start_job(3, 22'h1000, 22'h0, 32'd0);
    c = 0;
    while (tiles_loaded != CW'(2) && c < 200) begin tick(); c++; end
    if (c >= 200) chk("stall_timeout", 64'(tiles_loaded), 64'd2);
    repeat (8) tick();
    chk("stall_buf_full", 64'(buf_full), 64'h3);
    chk("stall_dma_start", 64'(dma_start), 64'd0);
    chk("stall_cmd_count", 64'(obs_q.size()), 64'd2);
    cons_release = 2'b01;
    c = 0;
    do begin tick(); c++; end while (dma_start == 2'b00 && c < 10);
    chk("stall_resume_code", 64'(dma_start), 64'h1);
    chk("stall_resume_addr", 64'(dma_addr), 64'h2520);
    rel_mode = 1;
    wait_done(300, cyc);
    chk("stall_tiles_loaded", 64'(tiles_loaded), 64'd3);

    // Tile address wraps at 22 bits.
    start_job(2, 22'h3FFFFF, 22'h0, 32'd0);
    wait_done(300, cyc);
    chk("wrap_cmd_count", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() == 2) begin
      chk("wrap_addr0", 64'(obs_q[0].addr), 64'h3FFFFF);
      chk("wrap_addr1", 64'(obs_q[1].addr), 64'd2703);
    end

    // Reset while a tile transfer is outstanding, then a late done.
    rel_mode = 0; done_dly = 50;
    start_job(2, 22'h500, 22'h0, 32'd0);
    c = 0;
    while (!(obs_q.size() == 1 && dma_start == 2'b00) && c < 30) begin tick(); c++; end
    repeat (2) tick();
    chk("midrst_in_flight", 64'(m_flight), 64'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_dma_start", 64'(dma_start), 64'd0);
    chk("midrst_dma_addr", 64'(dma_addr), 64'd0);
    chk("midrst_dma_size", 64'(dma_size), 64'd0);
    chk("midrst_dma_sram", 64'(dma_sram_size), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_tiles", 64'(tiles_loaded), 64'd0);
    dma_done = 1'b1;
    repeat (3) tick();
    chk("midrst_buf_full", 64'(buf_full), 64'd0);
    chk("midrst_busy_late", 64'(busy), 64'd0);
    done_dly = 0; rel_mode = 1;

    // Empty job: no commands, job_done within 3 cycles of go.
    start_job(0, 22'h123, 22'h456, 32'd0);
    wait_done(20, cyc);
    chk("empty_latency_le3", 64'(cyc <= 3), 64'd1);
    chk("empty_no_cmd", 64'(obs_q.size()), 64'd0);

    // Randomized jobs with stray handshakes, random releases and ignored go pulses.
    stray = 1'b1; rnd_go = 1'b1;
    for (int j = 0; j < 40; j++) begin
      int nt;
      logic [AW-1:0] ib;
      logic [31:0] ww;
      nt = int'($urandom_range(0, 6));
      ww = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
      ib = ($urandom_range(0, 3) == 0) ? AW'(22'h3FFFFF - 22'($urandom_range(0, 8000)))
                                       : AW'($urandom);
      rel_mode = ($urandom_range(0, 2) == 0) ? 1 : 2;
      start_job(nt, ib, AW'($urandom), ww);
      wait_done(3000, cyc);
      chk("rnd_cmd_count", 64'(obs_q.size()), 64'(nt + ((ww != 32'd0) ? 1 : 0)));
      chk("rnd_tiles_loaded", 64'(tiles_loaded), 64'(nt));
      repeat (int'($urandom_range(0, 3))) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_tile_scheduler.md
DMA_TILE_SCHEDULER -- requirements
Module: dma_tile_scheduler

Interface
REQ-001 Parameter TILE_WORDS, default 2704, means 32-bit words per image tile (52x52).
REQ-002 Parameter ADDR_W, default 22, means DRAM word-address width (12 row + 10 col bits).
REQ-003 Parameter CNT_W, default 16, means tile-counter width.
REQ-004 Port CLK, input, 1, is the single clock; all logic is rising-edge.
REQ-005 Port RST, input, 1, is the synchronous, active-high reset.
REQ-006 Port go, input, 1, is a job-start pulse, ignored while busy=1.
REQ-007 Port num_tiles, input, CNT_W, is the number of tiles in the job, sampled with go.
REQ-008 Port img_base, input, ADDR_W, is the first tile's DRAM address, sampled with go.
REQ-009 Port weight_base, input, ADDR_W, is the DRAM address of the weights, sampled with go.
REQ-010 Port weight_words, input, 32, is the weight length; 0 skips the weight load; sampled with go.
REQ-011 Port dma_start, output, 2, is the DMA command: 00 none, 11 weights, 01 ping buffer 0, 10 pong buffer 1.
REQ-012 Port dma_addr, output, ADDR_W, is the DRAM start address for the DMA.
REQ-013 Port dma_size, output, 32, is the DRAM transfer length in words.
REQ-014 Port dma_sram_size, output, 32, is the SRAM buffer capacity in words.
REQ-015 Port dma_started, input, 1, is the DMA's acknowledgement that it accepted the command.
REQ-016 Port dma_done, input, 1, is the DMA's one-cycle transfer-complete pulse.
REQ-017 Port buf_full, output, 2, gives per-buffer data-ready flags to the compute engine.
REQ-018 Port cons_release, input, 2, is a per-buffer pulse from the compute engine meaning the buffer has been consumed.
REQ-019 Port tiles_loaded, output, CNT_W, counts tiles completed in the current job.
REQ-020 Port busy, output, 1, is high from go acceptance until job_done.
REQ-021 Port job_done, output, 1, is a one-cycle job-complete pulse.

Function
REQ-022 All outputs SHALL be registered; the FSM states SHALL be IDLE, ISSUE_W, WAIT_W, PICK, ISSUE_T, WAIT_T, DRAIN and FINISH.
REQ-023 In IDLE, go=1 SHALL latch all job inputs, set busy, clear tiles_loaded and the next-buffer pointer (nxt=0), and go to ISSUE_W if weight_words!=0, else to PICK.
REQ-024 ISSUE_W SHALL drive dma_start=11, dma_addr=weight_base, dma_size=weight_words and dma_sram_size=weight_words, starting the cycle after go.
REQ-025 In ISSUE_W, dma_start SHALL hold until dma_started=1 is sampled, then return to 00 on the next cycle, and the FSM SHALL go to WAIT_W.
REQ-026 In WAIT_W, dma_done SHALL move the FSM to PICK.
REQ-027 In PICK, if tiles_loaded==num_tiles the FSM SHALL go to DRAIN; else if buf_full[nxt]==0 it SHALL go to ISSUE_T; otherwise it SHALL stall in PICK.
REQ-028 ISSUE_T SHALL drive dma_start=01 if nxt=0 or 10 if nxt=1, dma_addr=img_base+tiles_loaded*TILE_WORDS, dma_size=TILE_WORDS and dma_sram_size=TILE_WORDS, with the same hold/release rule as REQ-025, then go to WAIT_T.
REQ-029 The address sum SHALL truncate to ADDR_W bits, wrapping modulo 2^ADDR_W without error.
REQ-030 In WAIT_T, dma_done SHALL, in the same edge, set buf_full[nxt], toggle nxt, increment tiles_loaded, and move the FSM to PICK.
REQ-031 cons_release[i]=1 SHALL clear buf_full[i] on the next edge in any state.
REQ-032 A release of an already-empty buffer SHALL be ignored.
REQ-033 If set and clear target the same buffer bit in the same cycle, set SHALL win.
REQ-034 In DRAIN, the FSM SHALL wait until buf_full==00, then go to FINISH.
REQ-035 FINISH SHALL pulse job_done for one cycle, clear busy, and return to IDLE.
REQ-036 dma_done outside WAIT_W/WAIT_T and dma_started outside the ISSUE states SHALL be ignored.
REQ-037 num_tiles=0 SHALL give weights only (if weight_words!=0), then DRAIN/FINISH; with weight_words=0 as well, job_done SHALL follow go within 3 cycles.

Reset
REQ-038 RST=1 at a clock edge SHALL, in any state including mid-transfer, force IDLE, dma_start=00, dma_addr=0, dma_size=0, dma_sram_size=0, buf_full=00, tiles_loaded=0, nxt=0, busy=0 and job_done=0.
REQ-039 Any dma_done arriving after reset SHALL be ignored.

Verification
REQ-040 weight_words=8, num_tiles=2, img_base=0x100, consumer releases immediately -> dma_start sequence 11, 01 at 0x100, 10 at 0x100+2704; a single job_done; tiles_loaded=2.
REQ-041 num_tiles=3 with no release -> the third tile stalls in PICK with buf_full=11; a cons_release=01 pulse -> dma_start=01 is issued next.
REQ-042 img_base=0x3FFFFF, num_tiles=2 -> the second dma_addr equals 2703 (wrapped).
REQ-043 dma_started delayed 5 cycles -> dma_start is held stable for 5 cycles, then 00.
REQ-044 RST during WAIT_T, then a late dma_done -> all outputs at reset values; buf_full stays 00.
REQ-045 num_tiles=0 and weight_words=0 -> no DMA command is issued; job_done follows go within 3 cycles.
